// File: rtl/dram_cycarb_if.sv
// Bus bundle between the DRAM cycle arbiter and its clients (CPU side, video
// fetcher, DRAM controller). The slave modport is the arbiter's view.
interface dram_cycarb_if;
    logic        cbeg;
    logic        post_cbeg;
    logic        pre_cend;
    logic        cend;

    logic        cpu_req;
    logic        cpu_rnw;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_wrbsel;
    logic        cpu_next;
    logic        cpu_strobe;
    logic [15:0] cpu_rddata;

    logic        video_req;
    logic [20:0] video_addr;
    logic        video_next;
    logic        video_strobe;

    logic        dram_req;
    logic        dram_rnw;
    logic [20:0] dram_addr;
    logic [1:0]  dram_bsel;
    logic [15:0] dram_wrdata;
    logic        dram_rfsh;
    logic [15:0] dram_rddata;

    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel,
        input  video_req, video_addr, dram_rddata,
        output cbeg, post_cbeg, pre_cend, cend,
        output cpu_next, cpu_strobe, cpu_rddata, video_next, video_strobe,
        output dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata, dram_rfsh
    );

    modport master (
        output cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel,
        output video_req, video_addr, dram_rddata,
        input  cbeg, post_cbeg, pre_cend, cend,
        input  cpu_next, cpu_strobe, cpu_rddata, video_next, video_strobe,
        input  dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata, dram_rfsh
    );
endinterface

// File: rtl/dram_cycarb.sv
// DRAM cycle sequencer/arbiter: splits fclk into 4-clock DRAM cycles and
// hands each cycle to refresh, video, CPU or idle at the cend boundary.
//
// state | meaning
// IDLE  | no DRAM access this cycle
// CPU   | CPU read or write cycle
// VIDEO | video fetch (always a read)
// RFSH  | refresh cycle
module dram_cycarb #(
    parameter int RFSH_PERIOD  = 60,
    parameter int RFSH_MAXWAIT = 4
) (
    input logic          fclk,
    input logic          rst,
    dram_cycarb_if.slave bus
);
    localparam int CW = $clog2(RFSH_PERIOD);
    localparam int WW = $clog2(RFSH_MAXWAIT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(RFSH_PERIOD - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RFSH_MAXWAIT - 1);

    typedef enum logic [1:0] {IDLE, CPU, VIDEO, RFSH} owner_t;

    owner_t        owner;
    owner_t        grant;
    logic [1:0]    phase;
    logic [CW-1:0] rfsh_cnt;
    logic [WW-1:0] wait_cnt;
    logic          rfsh_pend;
    logic          rfsh_urgent;
    logic          cend;

    assign cend          = (phase == 2'd3);
    assign bus.cbeg      = (phase == 2'd0);
    assign bus.post_cbeg = (phase == 2'd1);
    assign bus.pre_cend  = (phase == 2'd2);
    assign bus.cend      = cend;

    always_comb begin
        grant = IDLE;
        if (rfsh_urgent)
            grant = RFSH;
        else if (bus.video_req)
            grant = VIDEO;
        else if (bus.cpu_req)
            grant = CPU;
        else if (rfsh_pend)
            grant = RFSH;
    end

    // Must stay identical to the CPU branch of the grant priority above.
    assign bus.cpu_next     = !bus.video_req && !rfsh_urgent;
    assign bus.cpu_strobe   = cend && (owner == CPU) && bus.dram_rnw;
    assign bus.video_strobe = cend && (owner == VIDEO);
    assign bus.video_next   = cend && (grant == VIDEO);
    assign bus.cpu_rddata   = bus.dram_rddata;

    always_ff @(posedge fclk) begin
        if (rst) begin
            phase           <= 2'd3;
            owner           <= IDLE;
            rfsh_cnt        <= '0;
            wait_cnt        <= '0;
            rfsh_pend       <= 1'b0;
            rfsh_urgent     <= 1'b0;
            bus.dram_req    <= 1'b0;
            bus.dram_rfsh   <= 1'b0;
            bus.dram_rnw    <= 1'b1;
            bus.dram_addr   <= '0;
            bus.dram_bsel   <= 2'b11;
            bus.dram_wrdata <= '0;
        end else begin
            phase <= phase + 2'd1;
            if (cend) begin
                owner         <= grant;
                bus.dram_req  <= (grant == CPU) || (grant == VIDEO);
                bus.dram_rfsh <= (grant == RFSH);
                case (grant)
                    CPU: begin
                        bus.dram_addr   <= bus.cpu_addr;
                        bus.dram_rnw    <= bus.cpu_rnw;
                        bus.dram_bsel   <= bus.cpu_rnw ? 2'b11 :
                                           (bus.cpu_wrbsel ? 2'b01 : 2'b10);
                        bus.dram_wrdata <= {bus.cpu_wrdata, bus.cpu_wrdata};
                    end
                    VIDEO: begin
                        bus.dram_addr <= bus.video_addr;
                        bus.dram_rnw  <= 1'b1;
                        bus.dram_bsel <= 2'b11;
                    end
                    default: ;
                endcase

                if (rfsh_cnt == CNT_LAST)
                    rfsh_cnt <= '0;
                else
                    rfsh_cnt <= rfsh_cnt + 1'b1;

                if (grant == RFSH) begin
                    rfsh_pend   <= 1'b0;
                    rfsh_urgent <= 1'b0;
                    wait_cnt    <= '0;
                end else if (rfsh_pend && !rfsh_urgent) begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_LAST)
                        rfsh_urgent <= 1'b1;
                end
                // A new period never stacks on an outstanding refresh.
                if (rfsh_cnt == CNT_LAST)
                    rfsh_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dram_cycarb.sv
// Bench for dram_cycarb: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration and refresh rules.
module tb_dram_cycarb;
    localparam int RFSH_PERIOD  = 60;
    localparam int RFSH_MAXWAIT = 4;

    logic fclk = 1'b0;
    logic rst  = 1'b1;
    always #5 fclk = ~fclk;

    dram_cycarb_if bus ();
    dram_cycarb #(.RFSH_PERIOD(RFSH_PERIOD), .RFSH_MAXWAIT(RFSH_MAXWAIT)) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef enum int {O_IDLE, O_CPU, O_VIDEO, O_RFSH} own_t;

    // model state: fclk index since reset release, completed cend count,
    // cend index at which the outstanding refresh became pending (-1 = none)
    int          cyc;
    int          cend_idx;
    int          pend_start;
    own_t        m_owner;
    logic [20:0] m_addr;
    logic        m_rnw;
    logic [1:0]  m_bsel;
    logic [15:0] m_wrdata;

    logic e_cbeg, e_post, e_pre, e_cend, e_cpu_next, e_urgent;
    logic e_cpu_strobe, e_video_strobe, e_video_next, e_dram_req, e_dram_rfsh;
    own_t e_grant;

    task automatic model_reset();
        cyc        = 1;
        cend_idx   = 0;
        pend_start = -1;
        m_owner    = O_IDLE;
        m_addr     = '0;
        m_rnw      = 1'b1;
        m_bsel     = 2'b11;
        m_wrdata   = '0;
    endtask

    task automatic model_eval();
        int ph;
        int k;
        bit pending;
        #1;
        ph = (cyc + 2) % 4;
        k  = cend_idx + 1;
        pending  = (pend_start >= 0) && (k > pend_start);
        e_urgent = pending && ((k - pend_start) >= RFSH_MAXWAIT + 1);
        e_cbeg = (ph == 0);
        e_post = (ph == 1);
        e_pre  = (ph == 2);
        e_cend = (ph == 3);
        if (e_urgent)           e_grant = O_RFSH;
        else if (bus.video_req) e_grant = O_VIDEO;
        else if (bus.cpu_req)   e_grant = O_CPU;
        else if (pending)       e_grant = O_RFSH;
        else                    e_grant = O_IDLE;
        e_cpu_next     = !bus.video_req && !e_urgent;
        e_video_next   = e_cend && (e_grant == O_VIDEO);
        e_cpu_strobe   = e_cend && (m_owner == O_CPU) && m_rnw;
        e_video_strobe = e_cend && (m_owner == O_VIDEO);
        e_dram_req     = (m_owner == O_CPU) || (m_owner == O_VIDEO);
        e_dram_rfsh    = (m_owner == O_RFSH);
    endtask

    task automatic step();
        int k;
        if (e_cend) begin
            k = cend_idx + 1;
            if (e_grant == O_CPU) begin
                m_addr   = bus.cpu_addr;
                m_rnw    = bus.cpu_rnw;
                m_bsel   = bus.cpu_rnw ? 2'b11 : (bus.cpu_wrbsel ? 2'b01 : 2'b10);
                m_wrdata = {bus.cpu_wrdata, bus.cpu_wrdata};
            end else if (e_grant == O_VIDEO) begin
                m_addr = bus.video_addr;
                m_rnw  = 1'b1;
                m_bsel = 2'b11;
            end
            if (e_grant == O_RFSH) pend_start = -1;
            if ((k % RFSH_PERIOD) == 0 && pend_start < 0) pend_start = k;
            m_owner  = e_grant;
            cend_idx = k;
        end
        cyc++;
        @(posedge fclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_rnw = 1; bus.cpu_addr = '0; bus.cpu_wrdata = '0;
        bus.cpu_wrbsel = 0; bus.video_req = 0; bus.video_addr = '0; bus.dram_rddata = '0;
        repeat (2) @(posedge fclk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int first_rfsh = -1;
        do_reset();
        for (int c = 1; c <= 4 * (RFSH_PERIOD + RFSH_MAXWAIT) + 8; c++) begin
            model_eval();
            if (c == 1) begin
                total++;
                if (bus.dram_rfsh !== 0 || bus.cpu_strobe !== 0 || bus.video_strobe !== 0) begin
                    bad++; $display("FAIL reset_ctrl: rfsh=%b cs=%b vs=%b, all must be 0",
                                    bus.dram_rfsh, bus.cpu_strobe, bus.video_strobe);
                end
                total++;
                if (bus.dram_addr !== 21'h0 || bus.dram_rnw !== 1'b1 || bus.dram_bsel !== 2'b11) begin
                    bad++; $display("FAIL reset_bus: addr=%h rnw=%b bsel=%b want 0/1/11",
                                    bus.dram_addr, bus.dram_rnw, bus.dram_bsel);
                end
            end
            total++;
            if ({bus.cend, bus.cbeg, bus.post_cbeg, bus.pre_cend} !==
                {c % 4 == 1, c % 4 == 2, c % 4 == 3, c % 4 == 0}) begin
                bad++; $display("FAIL phase_seq fclk %0d: got %b", c,
                                {bus.cend, bus.cbeg, bus.post_cbeg, bus.pre_cend});
            end
            total++;
            if (bus.dram_req !== 1'b0) begin
                bad++; $display("FAIL idle_req fclk %0d: got %b want 0", c, bus.dram_req);
            end
            if (bus.dram_rfsh === 1'b1 && first_rfsh < 0) first_rfsh = c;
            step();
        end
        total++;
        if (first_rfsh != 4 * (RFSH_PERIOD + 1) - 2) begin
            bad++; $display("FAIL idle_rfsh_time: got fclk %0d want %0d",
                            first_rfsh, 4 * (RFSH_PERIOD + 1) - 2);
        end
    endtask

    task automatic test_cpu_read();
        bit got = 0;
        do_reset();
        bus.cpu_req = 1; bus.cpu_rnw = 1; bus.cpu_addr = 21'h012345; bus.dram_rddata = 16'hA55A;
        for (int c = 0; c < 8 && !got; c++) begin
            model_eval();
            if (e_cend && e_grant == O_CPU) begin
                got = 1;
                total++;
                if (bus.cpu_next !== 1'b1) begin
                    bad++; $display("FAIL rd_cpu_next: got %b want 1", bus.cpu_next);
                end
            end
            step();
        end
        bus.cpu_req = 0;
        total++;
        if (!got) begin bad++; $display("FAIL rd_grant: got none want grant in 8 fclk"); end
        for (int i = 1; i <= 4; i++) begin
            model_eval();
            total++;
            if (bus.dram_req !== 1 || bus.dram_addr !== 21'h012345 || bus.dram_rnw !== 1) begin
                bad++; $display("FAIL rd_bus %0d: req=%b addr=%h rnw=%b want 1/012345/1",
                                i, bus.dram_req, bus.dram_addr, bus.dram_rnw);
            end
            total++;
            if (bus.cpu_strobe !== (i == 4)) begin
                bad++; $display("FAIL rd_strobe %0d: got %b want %b", i, bus.cpu_strobe, i == 4);
            end
            if (i == 4) begin
                total++;
                if (bus.cpu_rddata !== 16'hA55A) begin
                    bad++; $display("FAIL rd_data: got %h want a55a", bus.cpu_rddata);
                end
            end
            step();
        end
    endtask

    task automatic test_cpu_write();
        int wait_fclk = 0;
        bit got = 0;
        do_reset();
        repeat ($urandom_range(3)) begin model_eval(); step(); end
        bus.cpu_req = 1; bus.cpu_rnw = 0; bus.cpu_wrbsel = 1; bus.cpu_wrdata = 8'h3C;
        bus.cpu_addr = 21'($urandom);
        for (int c = 0; c < 8 && !got; c++) begin
            model_eval();
            wait_fclk++;
            if (e_cend && e_grant == O_CPU) got = 1;
            step();
        end
        bus.cpu_req = 0;
        total++;
        if (!got || wait_fclk > 4) begin
            bad++; $display("FAIL wr_accept: got %0d fclk want 1..4", wait_fclk);
        end
        for (int i = 1; i <= 4; i++) begin
            model_eval();
            total++;
            if (bus.dram_req !== 1 || bus.dram_rnw !== 0 || bus.dram_bsel !== 2'b01 ||
                bus.dram_wrdata !== 16'h3C3C) begin
                bad++; $display("FAIL wr_bus %0d: req=%b rnw=%b bsel=%b wd=%h want 1/0/01/3c3c",
                                i, bus.dram_req, bus.dram_rnw, bus.dram_bsel, bus.dram_wrdata);
            end
            total++;
            if (bus.cpu_strobe !== 1'b0) begin
                bad++; $display("FAIL wr_strobe %0d: got %b want 0", i, bus.cpu_strobe);
            end
            step();
        end
    endtask

    task automatic test_video_vs_cpu();
        logic [20:0] va = 21'($urandom);
        logic [20:0] ca = 21'($urandom);
        do_reset();
        bus.video_req = 1; bus.video_addr = va;
        bus.cpu_req = 1; bus.cpu_rnw = 1; bus.cpu_addr = ca;
        for (int c = 0; c < 12; c++) begin
            if (c == 10) bus.video_req = 0;
            model_eval();
            total++;
            if (bus.cpu_next !== (c >= 10)) begin
                bad++; $display("FAIL vc_cpu_next %0d: got %b want %b", c, bus.cpu_next, c >= 10);
            end
            total++;
            if (bus.video_next !== (c % 4 == 0) || bus.video_strobe !== (c % 4 == 0 && c > 0)) begin
                bad++; $display("FAIL vc_video %0d: next=%b strobe=%b", c, bus.video_next, bus.video_strobe);
            end
            if (c >= 1) begin
                total++;
                if (bus.dram_req !== 1 || bus.dram_addr !== va || bus.cpu_strobe !== 0) begin
                    bad++; $display("FAIL vc_vbus %0d: req=%b addr=%h cs=%b want 1/%h/0",
                                    c, bus.dram_req, bus.dram_addr, bus.cpu_strobe, va);
                end
            end
            step();
        end
        model_eval();
        total++;
        if (bus.cpu_next !== 1 || bus.video_next !== 0 || bus.video_strobe !== 1) begin
            bad++; $display("FAIL vc_handover: next=%b vnext=%b vstrobe=%b want 1/0/1",
                            bus.cpu_next, bus.video_next, bus.video_strobe);
        end
        step();
        bus.cpu_req = 0;
        bus.dram_rddata = 16'($urandom);
        for (int i = 1; i <= 4; i++) begin
            model_eval();
            total++;
            if (bus.dram_req !== 1 || bus.dram_addr !== ca || bus.cpu_strobe !== (i == 4)) begin
                bad++; $display("FAIL vc_cpu %0d: req=%b addr=%h strobe=%b want 1/%h/%b",
                                i, bus.dram_req, bus.dram_addr, bus.cpu_strobe, ca, i == 4);
            end
            step();
        end
    endtask

    task automatic test_video_rfsh();
        int first = -1;
        int nrfsh = 0;
        do_reset();
        bus.video_req = 1; bus.video_addr = 21'h1F0F0F;
        for (int c = 1; c <= 280; c++) begin
            model_eval();
            total++;
            if (bus.cpu_next !== 1'b0) begin
                bad++; $display("FAIL vr_cpu_next fclk %0d: got %b want 0", c, bus.cpu_next);
            end
            total++;
            if (bus.dram_rfsh !== e_dram_rfsh || bus.dram_req !== e_dram_req) begin
                bad++; $display("FAIL vr_owner fclk %0d: rfsh=%b req=%b want %b/%b",
                                c, bus.dram_rfsh, bus.dram_req, e_dram_rfsh, e_dram_req);
            end
            if (bus.dram_rfsh === 1'b1) begin
                nrfsh++;
                if (first < 0) first = c;
            end
            step();
        end
        total++;
        if (first != 4 * (RFSH_PERIOD + RFSH_MAXWAIT + 1) - 2 || nrfsh != 4) begin
            bad++; $display("FAIL vr_preempt: first=%0d len=%0d want %0d/4",
                            first, nrfsh, 4 * (RFSH_PERIOD + RFSH_MAXWAIT + 1) - 2);
        end
    endtask

    task automatic test_reset_abort();
        bit got = 0;
        do_reset();
        bus.cpu_req = 1; bus.cpu_rnw = 1; bus.cpu_addr = 21'($urandom);
        for (int c = 0; c < 8 && !got; c++) begin
            model_eval();
            if (e_cend && e_grant == O_CPU) got = 1;
            step();
        end
        bus.cpu_req = 0;
        model_eval();
        step();
        model_eval();
        total++;
        if (!got || bus.post_cbeg !== 1 || bus.dram_req !== 1) begin
            bad++; $display("FAIL ab_setup: got=%b post=%b req=%b want 1/1/1",
                            got, bus.post_cbeg, bus.dram_req);
        end
        rst = 1'b1;
        @(posedge fclk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 1; c <= 9; c++) begin
            model_eval();
            total++;
            if (bus.dram_req !== 0 || bus.dram_rfsh !== 0 || bus.cpu_strobe !== 0) begin
                bad++; $display("FAIL ab_quiet %0d: req=%b rfsh=%b strobe=%b want 0/0/0",
                                c, bus.dram_req, bus.dram_rfsh, bus.cpu_strobe);
            end
            total++;
            if (bus.cend !== (c % 4 == 1)) begin
                bad++; $display("FAIL ab_phase %0d: cend=%b want %b", c, bus.cend, c % 4 == 1);
            end
            step();
        end
    endtask

    task automatic test_random();
        bit granted;
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            if (!bus.cpu_req && $urandom_range(3) == 0) begin
                bus.cpu_req    = 1;
                bus.cpu_rnw    = 1'($urandom_range(1));
                bus.cpu_addr   = 21'($urandom);
                bus.cpu_wrdata = 8'($urandom);
                bus.cpu_wrbsel = 1'($urandom_range(1));
            end
            if ($urandom_range(7) == 0) bus.video_req = ~bus.video_req;
            bus.video_addr  = 21'($urandom);
            bus.dram_rddata = 16'($urandom);
            model_eval();
            total++;
            if ({bus.cbeg, bus.post_cbeg, bus.pre_cend, bus.cend} !== {e_cbeg, e_post, e_pre, e_cend}) begin
                bad++; $display("FAIL rnd_phase %0d: got %b", c,
                                {bus.cbeg, bus.post_cbeg, bus.pre_cend, bus.cend});
            end
            total++;
            if ({bus.cpu_next, bus.cpu_strobe, bus.video_strobe, bus.video_next} !==
                {e_cpu_next, e_cpu_strobe, e_video_strobe, e_video_next}) begin
                bad++; $display("FAIL rnd_hs %0d: got %b want %b", c,
                                {bus.cpu_next, bus.cpu_strobe, bus.video_strobe, bus.video_next},
                                {e_cpu_next, e_cpu_strobe, e_video_strobe, e_video_next});
            end
            total++;
            if (bus.dram_req !== e_dram_req || bus.dram_rfsh !== e_dram_rfsh ||
                bus.cpu_rddata !== bus.dram_rddata) begin
                bad++; $display("FAIL rnd_ctl %0d: req=%b rfsh=%b rd=%h want %b/%b/%h", c,
                                bus.dram_req, bus.dram_rfsh, bus.cpu_rddata,
                                e_dram_req, e_dram_rfsh, bus.dram_rddata);
            end
            if (e_dram_req) begin
                total++;
                if (bus.dram_addr !== m_addr || bus.dram_rnw !== m_rnw || bus.dram_bsel !== m_bsel ||
                    (!m_rnw && bus.dram_wrdata !== m_wrdata)) begin
                    bad++; $display("FAIL rnd_bus %0d: addr=%h rnw=%b bsel=%b wd=%h want %h/%b/%b/%h",
                                    c, bus.dram_addr, bus.dram_rnw, bus.dram_bsel, bus.dram_wrdata,
                                    m_addr, m_rnw, m_bsel, m_wrdata);
                end
            end
            granted = e_cend && (e_grant == O_CPU);
            step();
            if (granted) bus.cpu_req = 0;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_video_vs_cpu();
        test_video_rfsh();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_cycarb.md
# dram_cycarb

DRAM cycle sequencer and arbiter, sitting directly downstream of the Z80 memory manager. It divides fclk into fixed 4-clock DRAM cycles and publishes the phase strobes (cbeg/post_cbeg/pre_cend/cend) that the memory manager uses to size its wait states. At each cycle boundary it grants the next cycle to video, CPU, refresh or idle, drives the DRAM controller, and returns cpu_next/cpu_strobe/cpu_rddata to the CPU side.

## Interface
- RFSH_PERIOD, 60: DRAM cycles between refresh requests.
- RFSH_MAXWAIT, 4: DRAM cycles a pending refresh may wait before it becomes urgent.
- fclk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- cbeg, post_cbeg, pre_cend, cend  out  1 each  phase strobes; exactly one is high per fclk.
- cpu_req  in  1  CPU access request; held by the requester until granted.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_addr  in  21  word address.
- cpu_wrdata  in  8  write byte.
- cpu_wrbsel  in  1  byte select; 1 = low byte [7:0], 0 = high byte [15:8].
- cpu_next  out  1  next cycle is available to the CPU; valid in every phase.
- cpu_strobe  out  1  single-fclk pulse; cpu_rddata is valid.
- cpu_rddata  out  16  read word.
- video_req  in  1  video fetch request, level.
- video_addr  in  21  video word address.
- video_next  out  1  pulse: video_addr has been captured for the next cycle.
- video_strobe  out  1  pulse: video data is valid on cpu_rddata.
- dram_req  out  1  high for all 4 fclk of a granted read/write cycle.
- dram_rnw  out  1  direction of the current cycle.
- dram_addr  out  21  address of the current cycle.
- dram_bsel  out  2  write byte enables, {hi,lo}; 2'b11 on reads.
- dram_wrdata  out  16  write byte replicated to both halves.
- dram_rfsh  out  1  high for all 4 fclk of a refresh cycle.
- dram_rddata  in  16  controller read data; valid in the cend phase of a read cycle.

## Operation
- Phase counter (2 bits): 0 = cbeg, 1 = post_cbeg, 2 = pre_cend, 3 = cend; free-running and wraps 3 -> 0.
- Owner state, registered at cend for the following cycle: IDLE, CPU, VIDEO or RFSH.
- Grant priority evaluated at cend:
  - RFSH if refresh is urgent.
  - Otherwise VIDEO if video_req.
  - Otherwise CPU if cpu_req.
  - Otherwise RFSH if refresh is pending.
  - Otherwise IDLE.
- cpu_next is combinational: !video_req && !rfsh_urgent. It must equal exactly the CPU-grant condition at cend, so cpu_req && cpu_next at cend always yields a CPU grant.
- On a CPU or VIDEO grant, capture at cend: addr, rnw (video is always read), bsel and wrdata.
  - CPU write: bsel = cpu_wrbsel ? 2'b01 : 2'b10, wrdata = {cpu_wrdata, cpu_wrdata}.
- Pass-through: cpu_rddata = dram_rddata, combinational.
- cpu_strobe = cend && owner == CPU && dram_rnw.
- video_strobe = cend && owner == VIDEO.
- video_next = cend && grant == VIDEO.
- A CPU write raises no strobe.
- Refresh counter:
  - Counts cycles (increments at cend) and wraps at RFSH_PERIOD-1, setting rfsh_pend.
  - A second counter tracks how long rfsh_pend has been waiting; when it reaches RFSH_MAXWAIT, rfsh_urgent is set.
  - Granting RFSH clears both flags and the wait counter.
  - A period expiring while a refresh is still pending does not stack; it remains one pending refresh.
- Reset mid-operation: an in-progress cycle is aborted. dram_req and dram_rfsh drop at the next fclk edge, and no strobe is issued for the aborted cycle.

## Timing
- Reset values:
  - Phase = 3, so the first fclk after rst is deasserted is cend and the next is cbeg.
  - Owner = IDLE; all counters and flags cleared.
  - dram_req = 0, dram_rfsh = 0, strobes = 0, dram_bsel = 2'b11, dram_addr = 0, dram_rnw = 1.
- A grant decided at cend drives dram_* from the following cbeg through the next cend (4 fclk).
- Read latency from the grant edge: 4 fclk to cpu_strobe.
- Both cpu_next and cpu_req are sampled on the same cend; the requester drops cpu_req no earlier than the fclk after that cend.
- Write to cpu_req with no video or refresh load: accepted at the first cend after it rises, i.e. 1–4 fclk.
- cpu_next can change in any phase; only its value at cend is binding.

## Test plan
- Reset release, no requests: cend pulses on fclk 1, 5, 9, …; cbeg on fclk 2, 6, …; dram_req stays 0; a refresh occurs within 60 + 4 cycles.
- CPU read, addr 21'h012345, no competition: dram_req high for 4 fclk with dram_addr = 21'h012345 and dram_rnw = 1; cpu_strobe in the last of those fclk, with cpu_rddata equal to the dram_rddata value 16'hA55A.
- CPU write, cpu_wrbsel = 1, data 8'h3C: dram_bsel = 2'b01, dram_wrdata = 16'h3C3C, dram_rnw = 0; no cpu_strobe.
- video_req and cpu_req high together: cpu_next = 0; VIDEO is granted; the CPU is granted at the first cend after video_req drops.
- Continuous video_req from reset: refresh waits 4 cycles after becoming pending, then dram_rfsh preempts video for one cycle; cpu_next stays 0 throughout.
- rst asserted during the post_cbeg phase of a CPU read: dram_req is 0 on the next fclk; no cpu_strobe; the counter restarts at cend.
